stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control FSM that sequences the stopwatch seconds/minutes counter. It turns two synchronized push-button levels (start/stop, lap/reset) into the counter's one-cycle count-enable and clear pulses. It also produces a lap-hold flag for the display path. An internal prescaler divides the system clock to one count pulse per second while timing is active. The block sits between the button synchronizers and the counter/display datapath.

Parameters:
CLK_DIV, 12000000, system-clock cycles per counted second (legal range ≥2); prescaler width = $clog2(CLK_DIV).

Ports:
clk  input  1  system clock, rising edge.
nrst  input  1  asynchronous, active-low reset.
start_stop  input  1  start/stop button level, already synchronized to clk.
lap_reset  input  1  lap/reset button level, already synchronized to clk.
at_max  input  1  high when the counter holds its maximum value (99:59).
count_en  output  1  one-cycle pulse: the counter adds one second.
clear  output  1  one-cycle pulse: the counter goes to zero.
running  output  1  high in RUNNING or LAP.
lap_hold  output  1  high in LAP; the display freezes its latched value.
state_o  output  2  current state: IDLE=0, RUNNING=1, STOPPED=2, LAP=3.

Behaviour:
- Reset (nrst low, asynchronous): state=IDLE, prescaler=0, clear=0, edge-detect registers=0. Consequently count_en=0, running=0, lap_hold=0.
- Edge detect: ss_edge = start_stop & ~ss_q; lr_edge = lap_reset & ~lr_q. ss_q and lr_q register the previous button levels. A held button gives exactly one edge.
- Simultaneous ss_edge and lr_edge in the same cycle: ss_edge wins and lr_edge is discarded.
- The state register updates on the clock edge that ends the cycle in which the button edge is seen.
- Transitions:
  - IDLE: ss_edge -> RUNNING. lr_edge -> stay in IDLE and issue a clear pulse.
  - RUNNING: ss_edge -> STOPPED. lr_edge -> LAP.
  - LAP: ss_edge -> STOPPED (lap_hold drops). lr_edge -> RUNNING (lap released).
  - STOPPED: ss_edge -> RUNNING. lr_edge -> IDLE and issue a clear pulse.
  - RUNNING or LAP with count_en condition true and at_max=1 -> STOPPED (saturation).
- Prescaler:
  - Increments every cycle while state is RUNNING or LAP.
  - Wraps from CLK_DIV-1 to 0.
  - Holds its value in STOPPED, so a resume continues the partial second.
  - Resets to 0 on any clear pulse and on IDLE->RUNNING.
- count_en is combinational from registered state: (state==RUNNING or LAP) & prescaler==CLK_DIV-1 & ~at_max. It is never high for two consecutive cycles.
- at_max=1 at a terminal count: count_en stays 0, the counter holds 99:59, and the FSM goes to STOPPED.
- clear is a registered output, high for exactly one cycle, in the cycle after the qualifying lr_edge. It is never high together with count_en.
- running and lap_hold decode the registered state only (glitch-free).
- First count_en after IDLE->RUNNING: exactly CLK_DIV cycles after the state becomes RUNNING.
- Reset asserted mid-operation (any state, any prescaler value): everything returns to reset values immediately, and no clear pulse is issued.

Test Plan:
1. CLK_DIV=4. Reset, then press start_stop once (held 10 cycles). Required: state=RUNNING; count_en pulses on cycles 4, 8, 12 after entry; exactly one state change.
2. While RUNNING (prescaler=2), press start_stop. Required: state=STOPPED and count_en stays 0 for 20 cycles. Press start_stop again. Required: first count_en 2 cycles after re-entering RUNNING.
3. RUNNING, press lap_reset. Required: lap_hold=1 and count_en pulses continue every 4 cycles. Press lap_reset again. Required: lap_hold=0 and state=RUNNING.
4. STOPPED, press lap_reset. Required: clear=1 for exactly one cycle, state=IDLE, prescaler=0. In IDLE, press lap_reset. Required: one more clear pulse and state stays IDLE.
5. RUNNING with at_max=1 held when the prescaler reaches 3. Required: no count_en, state=STOPPED next cycle. start_stop and lap_reset rising together in RUNNING -> required: state=STOPPED and lap_hold=0.
6. Drop nrst while in LAP with prescaler=3. Required: all outputs 0 and state_o=0 without waiting for a clk edge; no clear pulse after nrst is released.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: turns synchronized button levels into count-enable
// and clear pulses for the seconds/minutes counter, with a one-second prescaler.
module stopwatch_ctrl #(
   parameter int unsigned CLK_DIV = 12000000
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       start_stop,
   input  logic       lap_reset,
   input  logic       at_max,
   output logic       count_en,
   output logic       clear,
   output logic       running,
   output logic       lap_hold,
   output logic [1:0] state_o
);

   localparam int unsigned PW = $clog2(CLK_DIV);
   localparam logic [PW-1:0] TERM = PW'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUNNING = 2'd1,
      S_STOPPED = 2'd2,
      S_LAP     = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [PW-1:0]   r_presc;
   logic [PW-1:0]   w_presc_nxt;
   logic            r_ss_q;
   logic            r_lr_q;
   logic            r_clear;
   logic            w_clear_nxt;
   logic            w_ss_edge;
   logic            w_lr_edge;
   logic            w_active;
   logic            w_tick;

   // start/stop has priority when both buttons rise in the same cycle
   assign w_ss_edge = start_stop & ~r_ss_q;
   assign w_lr_edge = lap_reset & ~r_lr_q & ~w_ss_edge;
   assign w_active  = (r_state == S_RUNNING) || (r_state == S_LAP);
   assign w_tick    = w_active && (r_presc == TERM);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state <= S_IDLE;
         r_presc <= '0;
         r_ss_q  <= 1'b0;
         r_lr_q  <= 1'b0;
         r_clear <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_presc <= w_presc_nxt;
         r_ss_q  <= start_stop;
         r_lr_q  <= lap_reset;
         r_clear <= w_clear_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_presc_nxt = r_presc;
      w_clear_nxt = 1'b0;

      if (w_active) begin
         w_presc_nxt = (r_presc == TERM) ? '0 : r_presc + PW'(1);
      end

      // a terminal count at the counter's maximum saturates into STOPPED
      if (w_tick && at_max) begin
         w_state_nxt = S_STOPPED;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_ss_edge) begin
                  w_state_nxt = S_RUNNING;
                  w_presc_nxt = '0;
               end else if (w_lr_edge) begin
                  w_clear_nxt = 1'b1;
                  w_presc_nxt = '0;
               end
            end
            S_RUNNING: begin
               if (w_ss_edge)      w_state_nxt = S_STOPPED;
               else if (w_lr_edge) w_state_nxt = S_LAP;
            end
            S_LAP: begin
               if (w_ss_edge)      w_state_nxt = S_STOPPED;
               else if (w_lr_edge) w_state_nxt = S_RUNNING;
            end
            S_STOPPED: begin
               if (w_ss_edge) begin
                  w_state_nxt = S_RUNNING;
               end else if (w_lr_edge) begin
                  w_state_nxt = S_IDLE;
                  w_clear_nxt = 1'b1;
                  w_presc_nxt = '0;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   assign count_en = w_tick & ~at_max;
   assign clear    = r_clear;
   assign running  = w_active;
   assign lap_hold = (r_state == S_LAP);
   assign state_o  = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_stopwatch_ctrl;

   localparam int unsigned DIV = 4;

   logic       clk;
   logic       nrst;
   logic       start_stop;
   logic       lap_reset;
   logic       at_max;
   logic       count_en;
   logic       clear;
   logic       running;
   logic       lap_hold;
   logic [1:0] state_o;

   int n_cmp = 0;
   int n_bad = 0;

   // behavioural model: state as plain integers, prescaler as a phase count
   int m_state;
   int m_phase;
   int m_ssq;
   int m_lrq;
   int m_clear;

   stopwatch_ctrl #(.CLK_DIV(DIV)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .start_stop (start_stop),
      .lap_reset  (lap_reset),
      .at_max     (at_max),
      .count_en   (count_en),
      .clear      (clear),
      .running    (running),
      .lap_hold   (lap_hold),
      .state_o    (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
      end
   endtask

   function automatic bit m_active();
      return (m_state == 1) || (m_state == 3);
   endfunction

   function automatic bit m_cnt();
      return m_active() && (m_phase == DIV - 1) && !at_max;
   endfunction

   task automatic model_reset();
      m_state = 0; m_phase = 0; m_ssq = 0; m_lrq = 0; m_clear = 0;
   endtask

   // advance the model by one clock using the inputs present at the edge
   task automatic model_step();
      bit ss, lr, sat;
      int ns;
      int nclr;
      ss   = start_stop && (m_ssq == 0);
      lr   = lap_reset && (m_lrq == 0) && !ss;
      sat  = m_active() && (m_phase == DIV - 1) && at_max;
      ns   = m_state;
      nclr = 0;
      if (sat) ns = 2;
      else if (ss) ns = (m_state == 0 || m_state == 2) ? 1 : 2;
      else if (lr) begin
         case (m_state)
            0: nclr = 1;
            1: ns = 3;
            3: ns = 1;
            default: begin ns = 0; nclr = 1; end
         endcase
      end
      if (nclr == 1 || (m_state == 0 && ns == 1)) m_phase = 0;
      else if (m_active()) m_phase = (m_phase + 1) % DIV;
      m_state = ns;
      m_clear = nclr;
      m_ssq   = start_stop ? 1 : 0;
      m_lrq   = lap_reset ? 1 : 0;
   endtask

   task automatic apply(input logic ss, input logic lr, input logic am);
      start_stop = ss; lap_reset = lr; at_max = am;
      #1;
   endtask

   task automatic check_model();
      chk("model_state", state_o, 2'(m_state));
      chk("model_count_en", {1'b0, count_en}, {1'b0, m_cnt()});
      chk("model_clear", {1'b0, clear}, 2'(m_clear));
      chk("model_running", {1'b0, running}, {1'b0, m_active()});
      chk("model_lap_hold", {1'b0, lap_hold}, {1'b0, m_state == 3});
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic drive(input logic ss, input logic lr, input logic am);
      apply(ss, lr, am);
      check_model();
      tick();
   endtask

   typedef struct {
      logic       ss;
      logic       lr;
      logic       am;
      logic [1:0] st;
      logic       cnt;
      logic       clr;
   } vec_t;

   vec_t vt[18];

   initial begin
      vt[0]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
      vt[1]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
      vt[2]  = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
      vt[3]  = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
      vt[4]  = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
      vt[5]  = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0};
      vt[6]  = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0};
      vt[7]  = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0};
      vt[8]  = '{1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0};
      vt[9]  = '{1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0};
      vt[10] = '{1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0};
      vt[11] = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
      vt[12] = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0};
      vt[13] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1};
      vt[14] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
      vt[15] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
      vt[16] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1};
      vt[17] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};

      nrst = 1'b0; start_stop = 1'b0; lap_reset = 1'b0; at_max = 1'b0;
      model_reset();
      #2;
      chk("reset_state", state_o, 2'd0);
      chk("reset_outs", {count_en, clear}, 2'b00);
      chk("reset_flags", {running, lap_hold}, 2'b00);
      repeat (2) @(posedge clk);
      @(negedge clk) nrst = 1'b1;
      @(posedge clk);
      #1;

      // directed table: start, counting, lap, stop, clear from STOPPED and IDLE
      for (int i = 0; i < 18; i++) begin
         apply(vt[i].ss, vt[i].lr, vt[i].am);
         chk($sformatf("vec%0d_state", i), state_o, vt[i].st);
         chk($sformatf("vec%0d_count_en", i), {1'b0, count_en}, {1'b0, vt[i].cnt});
         chk($sformatf("vec%0d_clear", i), {1'b0, clear}, {1'b0, vt[i].clr});
         check_model();
         tick();
      end

      // stop with a partial second, stay stopped, resume continues the second
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         apply(1'b0, 1'b0, 1'b0);
         chk("stopped_state", state_o, 2'd2);
         chk("stopped_count_en", {1'b0, count_en}, 2'd0);
         tick();
      end
      drive(1'b1, 1'b0, 1'b0);
      apply(1'b0, 1'b0, 1'b0);
      chk("resume_c1_state", state_o, 2'd1);
      chk("resume_c1_count_en", {1'b0, count_en}, 2'd0);
      tick();
      apply(1'b0, 1'b0, 1'b0);
      chk("resume_c2_count_en", {1'b0, count_en}, 2'd1);
      tick();

      // saturation at terminal count with at_max held
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1);
      apply(1'b0, 1'b0, 1'b1);
      chk("sat_term_state", state_o, 2'd1);
      chk("sat_term_count_en", {1'b0, count_en}, 2'd0);
      tick();
      apply(1'b0, 1'b0, 1'b0);
      chk("sat_after_state", state_o, 2'd2);
      chk("sat_after_running", {1'b0, running}, 2'd0);
      tick();

      // simultaneous button edges in RUNNING: start/stop wins
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      apply(1'b1, 1'b1, 1'b0);
      chk("both_state", state_o, 2'd2);
      chk("both_lap_hold", {1'b0, lap_hold}, 2'd0);
      tick();
      drive(1'b0, 1'b0, 1'b0);

      // asynchronous reset while in LAP at the terminal prescaler value
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 10 && !(m_state == 3 && m_phase == DIV - 1); i++)
         drive(1'b0, 1'b0, 1'b0);
      chk("lap_reached", 2'(m_state), state_o);
      apply(1'b0, 1'b0, 1'b0);
      chk("pre_reset_count_en", {1'b0, count_en}, 2'd1);
      nrst = 1'b0;
      #1;
      chk("async_state", state_o, 2'd0);
      chk("async_outs", {count_en, clear}, 2'b00);
      chk("async_flags", {running, lap_hold}, 2'b00);
      model_reset();
      @(negedge clk) nrst = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b0);

      // randomized button activity against the model
      begin
         logic ss, lr, am;
         ss = 1'b0; lr = 1'b0;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) ss = ~ss;
            if ($urandom_range(3) == 0) lr = ~lr;
            am = ($urandom_range(7) == 0);
            drive(ss, lr, am);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
